// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES datapath definitions: the 128-bit state type, the state geometry
// constants, and the byte-index to bit-position mapping of the column-major
// state (byte b = row + 4*col occupies bits [127-8b -: 8]).
// -----------------------------------------------------------------------------
package aes_pkg;

  typedef logic [127:0] aes_state_t;

  localparam int AES_NB     = 4;  // columns (and rows) of the state
  localparam int AES_BYTE_W = 8;

  // Most significant bit of byte b within the column-major state vector.
  function automatic int byte_msb(input int b);
    return 127 - AES_BYTE_W * b;
  endfunction

endpackage

// File: rtl/aes_shiftrows_core.sv
// -----------------------------------------------------------------------------
// aes_shiftrows_core
// Purely combinational AES ShiftRows byte permutation on a column-major state.
//   Forward : out[row][col] = in[row][(col+row) mod 4]
//   Inverse : out[row][col] = in[row][(col-row) mod 4]   (AES_SHIFTROWS_INV_EN)
// Ports:
//   state_i  in  128  state, column-major
//   inv_i    in  1    select InvShiftRows (only when AES_SHIFTROWS_INV_EN)
//   state_o  out 128  permuted state, column-major
// Without AES_SHIFTROWS_INV_EN the block is pure wiring with no inverse mux.
// -----------------------------------------------------------------------------
module aes_shiftrows_core
  import aes_pkg::*;
(
  input  aes_state_t state_i,
`ifdef AES_SHIFTROWS_INV_EN
  input  logic       inv_i,
`endif
  output aes_state_t state_o
);

  for (genvar r = 0; r < AES_NB; r++) begin : g_row
    for (genvar c = 0; c < AES_NB; c++) begin : g_col
      localparam int DST   = byte_msb(r + AES_NB * c);
      localparam int SRC_F = byte_msb(r + AES_NB * ((c + r) % AES_NB));
`ifdef AES_SHIFTROWS_INV_EN
      // +AES_NB keeps the modulo operand non-negative.
      localparam int SRC_I = byte_msb(r + AES_NB * ((c - r + AES_NB) % AES_NB));
      assign state_o[DST -: AES_BYTE_W] = inv_i ? state_i[SRC_I -: AES_BYTE_W]
                                                : state_i[SRC_F -: AES_BYTE_W];
`else
      assign state_o[DST -: AES_BYTE_W] = state_i[SRC_F -: AES_BYTE_W];
`endif
    end
  end

endmodule

// File: rtl/aes_shiftrows.sv
// -----------------------------------------------------------------------------
// aes_shiftrows
// Registered AES ShiftRows stage (between SubBytes and MixColumns). Permutes a
// column-major 128-bit state and presents it one cycle later through a
// valid/ready output register. Full throughput when out_ready stays high.
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    in_state valid this cycle
//   in_ready   out  1    stage can accept a state this cycle
//   in_state   in   128  state, column-major
//   inv        in   1    InvShiftRows select, sampled on accept
//                        (present only when AES_SHIFTROWS_INV_EN is defined)
//   out_valid  out  1    out_state holds a shifted state
//   out_ready  in   1    downstream accepts out_state this cycle
//   out_state  out  128  shifted state, registered
// Build option: define AES_SHIFTROWS_INV_EN to add the inverse permutation.
// -----------------------------------------------------------------------------
module aes_shiftrows
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
`ifdef AES_SHIFTROWS_INV_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  aes_state_t perm;
  aes_state_t state_q, state_d;
  logic       valid_q, valid_d;
  logic       accept;

  aes_shiftrows_core u_core (
    .state_i (in_state),
`ifdef AES_SHIFTROWS_INV_EN
    .inv_i   (inv),
`endif
    .state_o (perm)
  );

  // rst forces readiness so upstream never sees a stall while the stage is
  // being cleared; the held state is discarded anyway.
  assign in_ready = rst || !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Data only moves on accept; a plain drain just drops valid.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    if (accept) begin
      state_d = perm;
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign out_state = state_q;

endmodule

// File: tb/tb_aes_shiftrows.sv
// -----------------------------------------------------------------------------
// tb_aes_shiftrows
// Self-checking bench for aes_shiftrows. A negedge monitor keeps a scoreboard
// queue: reference results are pushed when an input handshake is seen and
// popped/compared when an output handshake is seen. Scenario tasks add their
// own directed checks. Inverse tests run when AES_SHIFTROWS_INV_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aes_shiftrows;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         inv_s;

  int n_tests = 0;
  int n_fail  = 0;
  logic [127:0] sb_q[$];

  always #5 clk = ~clk;

  aes_shiftrows dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
`ifdef AES_SHIFTROWS_INV_EN
    .inv       (inv_s),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  // Reference: each row gathered as a 32-bit word and rotated as a whole.
  function automatic logic [127:0] ref_sr(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [31:0]  w, rw;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      w = '0;
      for (int c = 0; c < 4; c++) w = (w << 8) | 32'(s[127 - 8*(r + 4*c) -: 8]);
      if (r == 0)   rw = w;
      else if (!inv) rw = (w << (8*r)) | (w >> (32 - 8*r));
      else           rw = (w >> (8*r)) | (w << (32 - 8*r));
      for (int c = 0; c < 4; c++) o[127 - 8*(r + 4*c) -: 8] = rw[31 - 8*c -: 8];
    end
    return o;
  endfunction

  // Scoreboard monitor: inputs are stable at negedge (driven 1ns after posedge).
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got out_state=%h with empty scoreboard", out_state);
        end else begin
          logic [127:0] e;
          e = sb_q.pop_front();
          if (out_state !== e) begin
            n_fail++;
            $display("FAIL sb_data: got %h expected %h", out_state, e);
          end
        end
      end
      if (in_valid && in_ready) sb_q.push_back(ref_sr(in_state, inv_s));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0; inv_s = 1'b0;
    cyc(); cyc();
    n_tests++;
    if (out_valid !== 1'b0 || out_state !== 128'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b s=%h rdy=%b required 0/0/1", out_valid, out_state, in_ready);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single(input string nm, input logic [127:0] s, input logic [127:0] exp);
    in_valid = 1'b1; in_state = s; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_state !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%b s=%h required v=1 s=%h", nm, out_valid, out_state, exp);
    end
    cyc();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: got out_valid=%b required 0", nm, out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a, b, ea, eb;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    ea = ref_sr(a, 1'b0); eb = ref_sr(b, 1'b0);
    out_ready = 1'b0; in_valid = 1'b1; in_state = a;
    cyc();
    in_state = b;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_state !== ea) begin
        n_fail++;
        $display("FAIL bp_stall%0d: got rdy=%b v=%b s=%h required 0/1/%h", i, in_ready, out_valid, out_state, ea);
      end
      cyc();
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_rdy: got in_ready=%b required 1", in_ready);
    end
    cyc();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_state !== eb) begin
      n_fail++;
      $display("FAIL bp_second: got v=%b s=%h required v=1 s=%h", out_valid, out_state, eb);
    end
    cyc();
    n_tests++;
    if (out_valid !== 1'b0 || out_state !== eb) begin
      n_fail++;
      $display("FAIL bp_drain_hold: got v=%b s=%h required v=0 s=%h", out_valid, out_state, eb);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp[8];
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_state = {$urandom, $urandom, $urandom, $urandom};
      exp[i] = ref_sr(in_state, 1'b0);
      cyc();
      n_tests++;
      if (out_valid !== 1'b1 || out_state !== exp[i]) begin
        n_fail++;
        $display("FAIL stream%0d: got v=%b s=%h required v=1 s=%h", i, out_valid, out_state, exp[i]);
      end
    end
    in_valid = 1'b0;
    cyc();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_end: got out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_stall();
    out_ready = 1'b0; in_valid = 1'b1;
    in_state = 128'h0123456789abcdeffedcba9876543210;
    cyc();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stall_pre: got v=%b rdy=%b required 1/0", out_valid, in_ready);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_in_ready: got in_ready=%b required 1", in_ready);
    end
    cyc();
    n_tests++;
    if (out_valid !== 1'b0 || out_state !== 128'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_stall_post: got v=%b s=%h rdy=%b required 0/0/1", out_valid, out_state, in_ready);
    end
    rst = 1'b0; out_ready = 1'b1;
    cyc();
  endtask

`ifdef AES_SHIFTROWS_INV_EN
  task automatic test_inverse();
    logic [127:0] r, f;
    inv_s = 1'b1;
    test_single("inv_fips", 128'hd4bf5d30e0b452aeb84111f11e2798e5,
                128'hd42711aee0bf98f1b8b45de51e415230);
    for (int i = 0; i < 4; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      inv_s = 1'b0; in_valid = 1'b1; in_state = r; out_ready = 1'b1;
      cyc();
      f = out_state;
      inv_s = 1'b1; in_state = f;
      cyc();
      in_valid = 1'b0; inv_s = 1'b0;
      n_tests++;
      if (out_valid !== 1'b1 || out_state !== r) begin
        n_fail++;
        $display("FAIL roundtrip%0d: got %h required %h", i, out_state, r);
      end
      cyc();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single("fips", 128'hd42711aee0bf98f1b8b45de51e415230,
                128'hd4bf5d30e0b452aeb84111f11e2798e5);
    test_single("index", 128'h000102030405060708090a0b0c0d0e0f,
                128'h00050a0f04090e03080d02070c01060b);
    test_backpressure();
    test_back_to_back();
    test_reset_stall();
`ifdef AES_SHIFTROWS_INV_EN
    test_inverse();
`endif
    cyc(); cyc();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d pending results required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
